// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state encoding
//   (3-bit) and default geometry of the instruction memory.
//   Optional feature macro: LOADER_CHECKSUM_EN (see prog_loader.sv).
package prog_loader_pkg;

    // Default instruction word width and instruction memory address width.
    localparam int unsigned LD_IW_DEF  = 8;
    localparam int unsigned LD_IMW_DEF = 4;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LEN  = 3'd1,
        LD_DATA = 3'd2,
        LD_CSUM = 3'd3,
        LD_DONE = 3'd4,
        LD_ERR  = 3'd5
    } ld_state_t;

    // Capacity of the instruction memory in words for a given address width.
    function automatic int unsigned ld_capacity(input int unsigned imw);
        return 32'd1 << imw;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader
//   Writer side of the core's instruction memory. Receives a program image as
//   a byte stream (valid/ready): a length byte N, N data bytes and, when
//   LOADER_CHECKSUM_EN is defined, one trailing XOR checksum byte. Each data
//   byte is written to instruction memory at consecutive addresses starting at
//   0; after a good frame core_start is raised and held until clear.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   : CSUM state present, trailing byte must equal XOR of data.
//     undefined : DATA goes straight to DONE after the Nth byte.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_data    in   IW   stream byte
//   in_valid   in   1    in_data valid
//   in_ready   out  1    loader accepts a byte (state-decoded only)
//   clear      in   1    synchronous return to IDLE from DONE/ERROR
//   imem_we    out  1    instruction memory write strobe (one-cycle pulse)
//   imem_addr  out  IMW  write address
//   imem_wdata out  IW   write data
//   core_start out  1    level; high = core runs
//   error      out  1    sticky load failure
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned IW  = LD_IW_DEF,
    parameter int unsigned IMW = LD_IMW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IW-1:0]  in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           clear,
    output logic           imem_we,
    output logic [IMW-1:0] imem_addr,
    output logic [IW-1:0]  imem_wdata,
    output logic           core_start,
    output logic           error
);

    localparam int unsigned CAP = ld_capacity(IMW);

    ld_state_t      state;
    logic [IW-1:0]  count;   // data bytes still expected
    logic [IMW-1:0] ptr;     // next write address; wraps after a full image
`ifdef LOADER_CHECKSUM_EN
    logic [IW-1:0]  csum;    // running XOR of accepted data bytes
`endif

    logic xfer;
    logic len_bad;
    logic last_byte;

    // Ready depends on state alone so the host may hold in_valid freely.
    assign in_ready  = (state == LD_LEN) || (state == LD_DATA) || (state == LD_CSUM);
    assign xfer      = in_valid & in_ready;

    // Length compared at full byte width so N > capacity is never truncated.
    assign len_bad   = (in_data == '0) || (32'(in_data) > CAP);
    assign last_byte = (count == IW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LD_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_start <= 1'b0;
            error      <= 1'b0;
            count      <= '0;
            ptr        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                LD_IDLE: begin
                    state <= LD_LEN;
                end

                LD_LEN: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state <= LD_ERR;
                            error <= 1'b1;
                        end else begin
                            count <= in_data;
                            ptr   <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                            state <= LD_DATA;
                        end
                    end
                end

                LD_DATA: begin
                    if (xfer) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= in_data;
                        ptr        <= ptr + 1'b1;
                        count      <= count - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= csum ^ in_data;
                        if (last_byte) begin
                            state <= LD_CSUM;
                        end
`else
                        if (last_byte) begin
                            state      <= LD_DONE;
                            core_start <= 1'b1;
                        end
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state      <= LD_DONE;
                            core_start <= 1'b1;
                        end else begin
                            state <= LD_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                LD_DONE: begin
                    if (clear) begin
                        state      <= LD_IDLE;
                        core_start <= 1'b0;
                    end
                end

                LD_ERR: begin
                    core_start <= 1'b0;
                    if (clear) begin
                        state <= LD_IDLE;
                        error <= 1'b0;
                    end
                end

                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Scoreboard bench for prog_loader. Expected writes are queued when a data
//   byte is issued; a monitor pops and compares on every imem_we pulse.
//   Honours LOADER_CHECKSUM_EN in the same way as the design.
module tb_prog_loader;

    localparam int IW  = 8;
    localparam int IMW = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [IW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic           clear;
    logic           imem_we;
    logic [IMW-1:0] imem_addr;
    logic [IW-1:0]  imem_wdata;
    logic           core_start;
    logic           error;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [IMW-1:0] addr;
        logic [IW-1:0]  data;
    } wr_t;

    wr_t        expq[$];
    logic [7:0] dbuf[16];

    prog_loader #(.IW(IW), .IMW(IMW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_start (core_start),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && imem_we === 1'b1) begin
                if (expq.size() == 0) begin
                    check("write_expected", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", 32'(imem_wdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bit ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!ok && waited < 20) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic gap();
        int n = int'($urandom_range(0, 2));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // Sends LEN + data (+ checksum) from dbuf; bad inverts the checksum byte.
    task automatic load_frame(input int n, input bit gaps, input bit bad);
        logic [7:0] x = '0;
        wr_t w;
        bit good = !(bad && CSUM_EN);
        send_byte(n[7:0]);
        for (int i = 0; i < n; i++) begin
            if (gaps) gap();
            w.addr = i[IMW-1:0];
            w.data = dbuf[i];
            expq.push_back(w);
            x ^= dbuf[i];
            send_byte(dbuf[i]);
        end
        if (CSUM_EN) begin
            check("csum_wait_start", 32'(core_start), 32'd0);
            check("csum_wait_ready", 32'(in_ready), 32'd1);
            if (gaps) gap();
            send_byte(bad ? ~x : x);
        end
        check("start_level", 32'(core_start), 32'(good));
        check("error_level", 32'(error), 32'(!good));
        check("ready_low_end", 32'(in_ready), 32'd0);
        tick(1);
        check("queue_drained", 32'(expq.size()), 32'd0);
    endtask

    task automatic clear_to_len(input string tag);
        do_clear();
        check({tag, "_clr_start"}, 32'(core_start), 32'd0);
        check({tag, "_clr_error"}, 32'(error), 32'd0);
        check({tag, "_clr_idle"}, 32'(in_ready), 32'd0);
        tick(1);
        check({tag, "_clr_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we), 32'd0);
        check({tag, "_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_start"}, 32'(core_start), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        tick(2);
        check_zero("reset");

        rst_n = 1'b1;
        check("idle_ready", 32'(in_ready), 32'd0);
        tick(1);
        check("len_ready", 32'(in_ready), 32'd1);

        // clear outside DONE/ERROR has no effect
        do_clear();
        check("clear_ignored", 32'(in_ready), 32'd1);

        // {03,11,22,33,(00)}
        dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
        load_frame(3, 1'b0, 1'b0);

        // input while not ready is ignored
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick(3);
        in_valid = 1'b0;
        check("done_hold_start", 32'(core_start), 32'd1);
        check("done_hold_ready", 32'(in_ready), 32'd0);
        clear_to_len("f1");

        // {02,A5,5A,00}: checksum wrong when enabled (correct is FF)
        dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
        load_frame(2, 1'b0, 1'b1);
        clear_to_len("f2");

        // LEN=00 and LEN=11 (17 > 16) are rejected immediately
        send_byte(8'h00);
        check("len0_error", 32'(error), 32'd1);
        check("len0_start", 32'(core_start), 32'd0);
        check("len0_ready", 32'(in_ready), 32'd0);
        tick(2);
        clear_to_len("len0");

        send_byte(8'h11);
        check("len17_error", 32'(error), 32'd1);
        check("len17_ready", 32'(in_ready), 32'd0);
        tick(2);
        clear_to_len("len17");

        // full-capacity image with random gaps
        for (int i = 0; i < 16; i++) dbuf[i] = 8'(i);
        load_frame(16, 1'b1, 1'b0);
        clear_to_len("f16");

        // reset during the second data byte of three
        begin
            wr_t w;
            send_byte(8'h03);
            w.addr = '0;
            w.data = 8'hC1;
            expq.push_back(w);
            send_byte(8'hC1);
            in_data  = 8'hC2;
            in_valid = 1'b1;
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_zero("midrst");
            in_valid = 1'b0;
            in_data  = '0;
            tick(1);
            check("midrst_queue", 32'(expq.size()), 32'd0);
            rst_n = 1'b1;
            tick(1);
            check("midrst_ready", 32'(in_ready), 32'd1);
        end

        // {02,AA,BB} after the aborted load
        dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
        load_frame(2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
